memory_game_ctrl: RTL and testbench

- Game-state engine for the 20-card pair-matching game.
- Takes raw active-low push buttons and owns the cursor, flip, match and move-count state. Exports per-card state vectors that the VGA renderer reads every pixel.
- Sits between the board keys and the pixel painter, and replaces the painter's free-running cursor logic.

---
 rtl/memory_game_pkg.sv | 28 ++
 rtl/button_debounce.sv | 39 +++
 rtl/memory_game_ctrl.sv | 100 ++++++++++
 tb/tb_memory_game_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the 20-card pair-matching game.
// The cursor stepper is also used by the renderer's bench model.
package memory_game_pkg;
   localparam int NUM_COLS  = 5;
   localparam int NUM_ROWS  = 4;
   localparam int NUM_PAIRS = 10;

   typedef logic [4:0] card_idx_t;

   typedef enum logic [2:0] {
      PICK1,
      PICK2,
      COMPARE,
      SHOW_MISS,
      DONE
   } game_state_t;

   // Row step wraps inside the column, then column step wraps across the board.
   function automatic card_idx_t cursor_step(card_idx_t pos, logic step_x, logic step_y);
      card_idx_t p;
      p = pos;
      if (step_y)
         p = (p[1:0] == 2'(NUM_ROWS - 1)) ? p - 5'(NUM_ROWS - 1) : p + 5'd1;
      if (step_x)
         p = (p < 5'(NUM_ROWS)) ? p + 5'(NUM_ROWS * (NUM_COLS - 1)) : p - 5'(NUM_ROWS);
      return p;
   endfunction
endpackage

// File: rtl/button_debounce.sv
// Active-low key debouncer: 2-FF synchroniser, stable-level counter and a
// single-cycle pulse on each accepted press.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         level <= 1'b1;
         count <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         press <= 1'b0;
         if (sync[1] == level) begin
            count <= '0;
         end else if (count == LAST) begin
            // Level accepted; only the released->pressed direction pulses.
            level <= sync[1];
            count <= '0;
            press <= level;
         end else begin
            count <= count + 1'b1;
         end
      end
   end
endmodule

// File: rtl/memory_game_ctrl.sv
// Game-state engine: debounced keys drive the cursor, flip/compare FSM,
// mismatch hold timer and score counters read by the VGA renderer.
module memory_game_ctrl
   import memory_game_pkg::*;
#(
   parameter int NUM_CARDS       = 20,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int MISMATCH_HOLD   = 50_000_000
) (
   input  logic                      clock_50M,
   input  logic                      reset_n,
   input  logic                      move_x,
   input  logic                      move_y,
   input  logic                      select,
   input  logic [NUM_CARDS-1:0][4:0] card_order,
   output card_idx_t                 cursor_pos,
   output logic [NUM_CARDS-1:0]      card_face_up,
   output logic [NUM_CARDS-1:0]      card_matched,
   output logic [3:0]                pairs_found,
   output logic [7:0]                moves,
   output logic                      game_done
);
   localparam int HW = (MISMATCH_HOLD > 1) ? $clog2(MISMATCH_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MISMATCH_HOLD - 1);

   logic        step_x, step_y, pick, avail;
   game_state_t state;
   card_idx_t   first, second;
   logic [HW-1:0] hold;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_x (
      .clk(clock_50M), .rst_n(reset_n), .key(move_x), .press(step_x));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_y (
      .clk(clock_50M), .rst_n(reset_n), .key(move_y), .press(step_y));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s (
      .clk(clock_50M), .rst_n(reset_n), .key(select), .press(pick));

   assign avail = !card_face_up[cursor_pos] && !card_matched[cursor_pos];

   always_ff @(posedge clock_50M or negedge reset_n) begin
      if (!reset_n) begin
         state        <= PICK1;
         cursor_pos   <= '0;
         card_face_up <= '0;
         card_matched <= '0;
         pairs_found  <= '0;
         moves        <= '0;
         game_done    <= 1'b0;
         first        <= '0;
         second       <= '0;
         hold         <= '0;
      end else begin
         // Selects below use the pre-move cursor value.
         if (state != DONE)
            cursor_pos <= cursor_step(cursor_pos, step_x, step_y);
         case (state)
            PICK1: if (pick && avail) begin
               card_face_up[cursor_pos] <= 1'b1;
               first <= cursor_pos;
               state <= PICK2;
            end
            PICK2: if (pick && avail) begin
               card_face_up[cursor_pos] <= 1'b1;
               second <= cursor_pos;
               if (moves != 8'hFF) moves <= moves + 8'd1;
               state <= COMPARE;
            end
            COMPARE: begin
               if (((card_order[first] ^ card_order[second]) & 5'b11110) == 5'd0) begin
                  card_matched[first]  <= 1'b1;
                  card_matched[second] <= 1'b1;
                  card_face_up[first]  <= 1'b0;
                  card_face_up[second] <= 1'b0;
                  pairs_found <= pairs_found + 4'd1;
                  if (pairs_found == 4'(NUM_PAIRS - 1)) begin
                     game_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= PICK1;
                  end
               end else begin
                  hold  <= HOLD_LAST;
                  state <= SHOW_MISS;
               end
            end
            SHOW_MISS: begin
               if (hold == '0) begin
                  card_face_up[first]  <= 1'b0;
                  card_face_up[second] <= 1'b0;
                  state <= PICK1;
               end else begin
                  hold <= hold - 1'b1;
               end
            end
            DONE:    game_done <= 1'b1;
            default: state <= PICK1;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with short debounce and hold times.
module tb_memory_game_ctrl;
   import memory_game_pkg::*;

   logic clock_50M = 1'b0;
   logic reset_n = 1'b0;
   logic move_x = 1'b1, move_y = 1'b1, select = 1'b1;
   logic [19:0][4:0] card_order;
   card_idx_t   cursor_pos;
   logic [19:0] card_face_up, card_matched;
   logic [3:0]  pairs_found;
   logic [7:0]  moves;
   logic        game_done;

   int errors = 0;
   int checks = 0;

   memory_game_ctrl #(.NUM_CARDS(20), .DEBOUNCE_CYCLES(4), .MISMATCH_HOLD(8)) dut (
      .clock_50M(clock_50M), .reset_n(reset_n), .move_x(move_x), .move_y(move_y),
      .select(select), .card_order(card_order), .cursor_pos(cursor_pos),
      .card_face_up(card_face_up), .card_matched(card_matched),
      .pairs_found(pairs_found), .moves(moves), .game_done(game_done));

   always #5 clock_50M = ~clock_50M;

   task automatic do_reset();
      reset_n = 1'b0;
      move_x = 1'b1; move_y = 1'b1; select = 1'b1;
      repeat (3) @(negedge clock_50M);
      reset_n = 1'b1;
      repeat (2) @(negedge clock_50M);
   endtask

   task automatic press(input bit x, input bit y, input bit s, input int hold_cyc);
      @(negedge clock_50M);
      if (x) move_x = 1'b0;
      if (y) move_y = 1'b0;
      if (s) select = 1'b0;
      repeat (hold_cyc) @(negedge clock_50M);
      move_x = 1'b1; move_y = 1'b1; select = 1'b1;
      repeat (12) @(negedge clock_50M);
   endtask

   // Select press that counts cycles in which every card in mask is face-up.
   task automatic press_count(input logic [19:0] mask, output int n);
      n = 0;
      @(negedge clock_50M);
      select = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock_50M);
         if (i == 9) select = 1'b1;
         if ((card_face_up & mask) == mask) n++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (cursor_pos !== 5'd0) begin
         errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor_pos);
      end
      checks++;
      if ({card_face_up, card_matched} !== 40'd0) begin
         errors++; $display("FAIL reset_cards got=%h/%h exp=0/0", card_face_up, card_matched);
      end
      checks++;
      if ({pairs_found, moves, game_done} !== 13'd0) begin
         errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", pairs_found, moves, game_done);
      end
   endtask

   task automatic test_cursor();
      int ys[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         press(0, 1, 0, 10);
         checks++;
         if (cursor_pos !== 5'(ys[i])) begin
            errors++; $display("FAIL cursor_y[%0d] got=%0d exp=%0d", i, cursor_pos, ys[i]);
         end
      end
      press(1, 0, 0, 10);
      checks++;
      if (cursor_pos !== 5'd17) begin
         errors++; $display("FAIL cursor_x got=%0d exp=17", cursor_pos);
      end
   endtask

   task automatic test_debounce();
      do_reset();
      @(negedge clock_50M);
      select = 1'b0;
      repeat (2) @(negedge clock_50M);
      select = 1'b1;
      repeat (20) @(negedge clock_50M);
      checks++;
      if (card_face_up !== 20'd0) begin
         errors++; $display("FAIL glitch_flip got=%h exp=0", card_face_up);
      end
      press(0, 0, 1, 100);
      checks++;
      if (card_face_up !== 20'h1 || moves !== 8'd0 || dut.state !== PICK2) begin
         errors++; $display("FAIL held_press got=%h moves=%0d st=%0d exp=00001 0 %0d",
                            card_face_up, moves, dut.state, PICK2);
      end
   endtask

   task automatic test_match();
      int n;
      do_reset();
      press(0, 0, 1, 10);
      press(0, 1, 0, 10);
      press_count(20'h3, n);
      checks++;
      if (n !== 1) begin
         errors++; $display("FAIL match_show_cycles got=%0d exp=1", n);
      end
      checks++;
      if (card_matched !== 20'h3 || card_face_up !== 20'h0) begin
         errors++; $display("FAIL match_cards got=%h/%h exp=00003/00000", card_matched, card_face_up);
      end
      checks++;
      if (pairs_found !== 4'd1 || moves !== 8'd1 || dut.state !== PICK1) begin
         errors++; $display("FAIL match_counts got=%0d/%0d st=%0d exp=1/1 st=%0d",
                            pairs_found, moves, dut.state, PICK1);
      end
   endtask

   task automatic test_mismatch();
      int n;
      do_reset();
      press(0, 0, 1, 10);
      repeat (4) press(1, 0, 0, 10);
      checks++;
      if (cursor_pos !== 5'd4) begin
         errors++; $display("FAIL miss_cursor got=%0d exp=4", cursor_pos);
      end
      press_count(20'h11, n);
      checks++;
      if (n !== 9) begin
         errors++; $display("FAIL miss_show_cycles got=%0d exp=9", n);
      end
      checks++;
      if (card_face_up !== 20'h0 || card_matched !== 20'h0 || moves !== 8'd1 ||
          pairs_found !== 4'd0 || dut.state !== PICK1) begin
         errors++; $display("FAIL miss_after got=%h/%h moves=%0d pairs=%0d exp=0/0 1 0",
                            card_face_up, card_matched, moves, pairs_found);
      end
   endtask

   task automatic test_full_game();
      do_reset();
      // Columns visited 0,4,3,2,1; each column flips rows 0..3 in order.
      for (int c = 0; c < 5; c++) begin
         for (int r = 0; r < 4; r++) begin
            press(0, 0, 1, 10);
            press(0, 1, 0, 10);
         end
         press(1, 0, 0, 10);
      end
      checks++;
      if (game_done !== 1'b1 || pairs_found !== 4'd10 || moves !== 8'd10) begin
         errors++; $display("FAIL game_done got=%0d pairs=%0d moves=%0d exp=1 10 10",
                            game_done, pairs_found, moves);
      end
      checks++;
      if (card_matched !== 20'hFFFFF || card_face_up !== 20'h0 || cursor_pos !== 5'd7) begin
         errors++; $display("FAIL game_board got=%h/%h cur=%0d exp=fffff/00000 7",
                            card_matched, card_face_up, cursor_pos);
      end
      press(1, 1, 1, 10);
      checks++;
      if (game_done !== 1'b1 || pairs_found !== 4'd10 || moves !== 8'd10 ||
          cursor_pos !== 5'd7 || card_matched !== 20'hFFFFF) begin
         errors++; $display("FAIL done_frozen got=%0d/%0d/%0d cur=%0d exp=1/10/10 cur=7",
                            game_done, pairs_found, moves, cursor_pos);
      end
   endtask

   task automatic test_both_moves();
      do_reset();
      repeat (3) press(0, 1, 0, 10);
      checks++;
      if (cursor_pos !== 5'd3) begin
         errors++; $display("FAIL both_pre got=%0d exp=3", cursor_pos);
      end
      press(1, 1, 0, 10);
      checks++;
      if (cursor_pos !== 5'd16) begin
         errors++; $display("FAIL both_moves got=%0d exp=16", cursor_pos);
      end
   endtask

   task automatic test_async_reset();
      bit seen;
      seen = 1'b0;
      do_reset();
      press(0, 0, 1, 10);
      repeat (4) press(1, 0, 0, 10);
      @(negedge clock_50M);
      select = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock_50M);
         if (i == 9) select = 1'b1;
         if (card_face_up == 20'h11) begin
            seen = 1'b1;
            break;
         end
      end
      select = 1'b1;
      checks++;
      if (!seen) begin
         errors++; $display("FAIL arst_setup got=%h exp=00011", card_face_up);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({cursor_pos, card_face_up, card_matched, pairs_found, moves, game_done} !== 58'd0 ||
          dut.state !== PICK1) begin
         errors++; $display("FAIL arst_outputs got=%0d/%h/%h/%0d/%0d/%0d exp=all 0",
                            cursor_pos, card_face_up, card_matched, pairs_found, moves, game_done);
      end
      repeat (2) @(negedge clock_50M);
      reset_n = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 20; k++) card_order[k] = 5'(k);
      test_reset();
      test_cursor();
      test_debounce();
      test_match();
      test_mismatch();
      test_full_game();
      test_both_moves();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
